// File: rtl/fan_sched_ctrl.sv
// Fan operating-state controller: speed sequencing across NORMAL/NATURAL/SLEEP modes
// plus the timed-shutdown countdown and its blinking indicator.
module fan_sched_ctrl #(
    parameter int TIMER_STEP_S   = 60,
    parameter int TIMER_MAX_S    = 480,
    parameter int NATURAL_PERIOD = 4,
    parameter int SLEEP_PERIOD   = 8,
    parameter int CNT_W          = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1s,
    input  logic             tick_250ms,
    input  logic             key_power,
    input  logic             key_speed,
    input  logic             key_mode,
    input  logic             key_timer,
    output logic [1:0]       speed,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] remain_s,
    output logic             timer_active,
    output logic             led_blink
);

    localparam int PH_MAX = (NATURAL_PERIOD > SLEEP_PERIOD) ? NATURAL_PERIOD : SLEEP_PERIOD;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {NORMAL = 2'd0, NATURAL = 2'd1, SLEEP = 2'd2} mode_e;

    mode_e             mode_q;
    logic [PH_W-1:0]   phase;
    logic              dir_up;

    logic              is_on;
    logic              dec;
    logic [CNT_W-1:0]  rem_d;
    logic [CNT_W:0]    sum;
    logic              over;
    logic              expire;
    logic              act_n;
    logic              clr;
    logic [PH_W-1:0]   phase_inc;
    logic              nat_hit;
    logic              slp_hit;

    assign mode = mode_q;

    always_comb begin
        is_on     = (speed != 2'd0);
        dec       = tick_1s & timer_active;
        rem_d     = remain_s - CNT_W'(dec);
        sum       = {1'b0, rem_d} + (CNT_W+1)'(TIMER_STEP_S);
        over      = (sum > (CNT_W+1)'(TIMER_MAX_S));
        // A timer press in the same cycle as the final decrement rescues the fan.
        expire    = dec & (rem_d == '0) & ~key_timer;
        act_n     = key_timer ? ~over : timer_active;
        clr       = ~rst_n | key_power | (is_on & expire);
        phase_inc = phase + PH_W'(1);
        nat_hit   = (mode_q == NATURAL) && (phase_inc == PH_W'(NATURAL_PERIOD));
        slp_hit   = (mode_q == SLEEP)   && (phase_inc == PH_W'(SLEEP_PERIOD));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            // Power press while OFF is the only clearing event that turns the fan on.
            speed        <= (rst_n && key_power && !is_on) ? 2'd1 : 2'd0;
            mode_q       <= NORMAL;
            remain_s     <= '0;
            timer_active <= 1'b0;
            led_blink    <= 1'b0;
            phase        <= '0;
            dir_up       <= 1'b1;
        end else if (is_on) begin
            if (key_timer) begin
                remain_s     <= over ? '0 : sum[CNT_W-1:0];
                timer_active <= ~over;
            end else begin
                remain_s     <= rem_d;
            end
            led_blink <= act_n ? (led_blink ^ (tick_250ms & timer_active)) : 1'b0;

            if (key_speed) begin
                speed  <= (speed == 2'd3) ? 2'd1 : speed + 2'd1;
                phase  <= '0;
                dir_up <= 1'b1;
            end else if (key_mode) begin
                case (mode_q)
                    NORMAL:  mode_q <= NATURAL;
                    NATURAL: mode_q <= SLEEP;
                    default: mode_q <= NORMAL;
                endcase
                phase  <= '0;
                dir_up <= 1'b1;
            end else if (tick_1s && mode_q != NORMAL) begin
                if (nat_hit) begin
                    phase <= '0;
                    // Ping-pong: bounce off HIGH and LOW so the sequence never pauses at an end.
                    if (dir_up) begin
                        if (speed == 2'd3) begin
                            speed  <= 2'd2;
                            dir_up <= 1'b0;
                        end else begin
                            speed  <= speed + 2'd1;
                        end
                    end else begin
                        if (speed == 2'd1) begin
                            speed  <= 2'd2;
                            dir_up <= 1'b1;
                        end else begin
                            speed  <= speed - 2'd1;
                        end
                    end
                end else if (slp_hit) begin
                    phase <= '0;
                    speed <= (speed > 2'd1) ? speed - 2'd1 : 2'd1;
                end else begin
                    phase <= phase_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fan_sched_ctrl.sv
// Directed-vector bench for fan_sched_ctrl with hand-computed expectations.
module tb_fan_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1s, tick_250ms;
    logic       key_power, key_speed, key_mode, key_timer;
    logic [1:0] speed, mode;
    logic [8:0] remain_s;
    logic       timer_active, led_blink;

    int n_chk = 0;
    int n_err = 0;

    fan_sched_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .tick_250ms(tick_250ms),
        .key_power(key_power), .key_speed(key_speed), .key_mode(key_mode),
        .key_timer(key_timer), .speed(speed), .mode(mode), .remain_s(remain_s),
        .timer_active(timer_active), .led_blink(led_blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic cyc(input bit p, input bit s, input bit m, input bit t,
                       input bit t1, input bit tq);
        key_power = p; key_speed = s; key_mode = m; key_timer = t;
        tick_1s = t1; tick_250ms = tq;
        @(posedge clk); #1;
        key_power = 0; key_speed = 0; key_mode = 0; key_timer = 0;
        tick_1s = 0; tick_250ms = 0;
    endtask

    task automatic chk_off(input string tag);
        chk({tag, ".speed"}, int'(speed), 0);
        chk({tag, ".mode"}, int'(mode), 0);
        chk({tag, ".remain"}, int'(remain_s), 0);
        chk({tag, ".active"}, int'(timer_active), 0);
        chk({tag, ".led"}, int'(led_blink), 0);
    endtask

    initial begin
        int nat_exp [4];
        nat_exp = '{2, 3, 2, 1};
        rst_n = 0;
        key_power = 0; key_speed = 0; key_mode = 0; key_timer = 0;
        tick_1s = 0; tick_250ms = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_off("reset");
        rst_n = 1;

        // Power on / off
        cyc(1,0,0,0,0,0);
        chk("pwr_on.speed", int'(speed), 1);
        chk("pwr_on.mode", int'(mode), 0);
        chk("pwr_on.remain", int'(remain_s), 0);
        chk("pwr_on.led", int'(led_blink), 0);
        cyc(1,0,0,0,0,0);
        chk("pwr_off.speed", int'(speed), 0);

        // Keys ignored while OFF
        cyc(0,1,0,0,0,0);
        cyc(0,0,1,0,0,0);
        cyc(0,0,0,1,0,0);
        cyc(0,0,0,0,1,1);
        chk_off("off_keys");

        // Speed and mode cycling
        cyc(1,0,0,0,0,0);
        cyc(0,1,0,0,0,0); chk("spd1", int'(speed), 2);
        cyc(0,1,0,0,0,0); chk("spd2", int'(speed), 3);
        cyc(0,1,0,0,0,0); chk("spd3", int'(speed), 1);
        cyc(0,0,1,0,0,0); chk("mode1", int'(mode), 1);
        cyc(0,0,1,0,0,0); chk("mode2", int'(mode), 2);
        cyc(0,0,1,0,0,0); chk("mode3", int'(mode), 0);
        chk("mode3.speed", int'(speed), 1);

        // NATURAL ping-pong from LOW
        cyc(0,0,1,0,0,0);
        for (int i = 1; i <= 16; i++) begin
            cyc(0,0,0,0,1,0);
            if (i == 3) chk("nat_t3", int'(speed), 1);
            if (i % 4 == 0) chk($sformatf("nat_t%0d", i), int'(speed), nat_exp[i/4-1]);
        end

        // SLEEP step-down from HIGH
        cyc(0,0,1,0,0,0);
        chk("sleep.mode", int'(mode), 2);
        cyc(0,1,0,0,0,0);
        cyc(0,1,0,0,0,0);
        chk("sleep.start", int'(speed), 3);
        for (int i = 1; i <= 24; i++) begin
            cyc(0,0,0,0,1,0);
            if (i == 7)  chk("slp_t7", int'(speed), 3);
            if (i == 8)  chk("slp_t8", int'(speed), 2);
            if (i == 16) chk("slp_t16", int'(speed), 1);
            if (i == 24) chk("slp_t24", int'(speed), 1);
        end

        // Timer add then cancel
        cyc(1,0,0,0,0,0);
        cyc(1,0,0,0,0,0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0,0,0,1,0,0);
            chk($sformatf("tmr_add%0d", i), int'(remain_s), 60*i);
            chk($sformatf("tmr_act%0d", i), int'(timer_active), 1);
        end
        cyc(0,0,0,0,0,1);
        chk("tmr.led_on", int'(led_blink), 1);
        cyc(0,0,0,1,0,0);
        chk("tmr_cancel.remain", int'(remain_s), 0);
        chk("tmr_cancel.active", int'(timer_active), 0);
        chk("tmr_cancel.led", int'(led_blink), 0);
        cyc(0,0,0,0,0,1);
        chk("led_idle", int'(led_blink), 0);

        // LED toggling, countdown and expiry
        cyc(0,0,0,1,0,0);
        chk("cd.start", int'(remain_s), 60);
        cyc(0,0,0,0,0,1); chk("led_t1", int'(led_blink), 1);
        cyc(0,0,0,0,0,1); chk("led_t2", int'(led_blink), 0);
        cyc(0,0,0,0,0,1); chk("led_t3", int'(led_blink), 1);
        for (int i = 1; i <= 59; i++) begin
            cyc(0,0,0,0,1,0);
            chk($sformatf("cd_%0d", i), int'(remain_s), 60 - i);
        end
        chk("cd.speed_before", int'(speed), 1);
        cyc(0,0,0,0,1,0);
        chk_off("expire");
        cyc(1,0,0,0,0,1);
        chk("post_exp.led", int'(led_blink), 0);

        // Timer press in the expiry cycle rescues the fan
        cyc(0,1,0,0,0,0);
        cyc(0,0,0,1,0,0);
        repeat (59) cyc(0,0,0,0,1,0);
        chk("rescue.pre", int'(remain_s), 1);
        cyc(0,0,0,1,1,0);
        chk("rescue.remain", int'(remain_s), 60);
        chk("rescue.speed", int'(speed), 2);
        chk("rescue.active", int'(timer_active), 1);

        // key_power beats key_speed
        cyc(1,1,0,0,0,0);
        chk_off("pwr_prio");

        // Reset mid-countdown
        cyc(1,0,0,0,0,0);
        cyc(0,0,1,0,0,0);
        cyc(0,0,0,1,0,0);
        repeat (30) cyc(0,0,0,0,1,0);
        chk("mid.remain", int'(remain_s), 30);
        rst_n = 0;
        cyc(0,1,0,1,1,1);
        chk_off("mid_reset");
        rst_n = 1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
